system_0_sd_wp_poller: RTL and testbench

Avalon-MM master that periodically reads a 1-bit PIO input slave (the SD-card write-protect PIO, register 0, bit 0) and debounces the sampled level. It publishes a stable level, a one-cycle change strobe and a sticky interrupt. It sits beside the PIO slave on the system interconnect, so the SD-card driver never has to poll the pin itself.

---
 rtl/system_0_sd_wp_poller.sv | 102 ++++++++++
 tb/tb_system_0_sd_wp_poller.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/system_0_sd_wp_poller.sv
// system_0_sd_wp_poller: Avalon-MM master polling a 1-bit PIO and debouncing it.
module system_0_sd_wp_poller #(
  parameter int   POLL_DIV       = 1024,
  parameter int   DEBOUNCE_COUNT = 4,
  parameter int   READ_LATENCY   = 1,
  parameter logic RESET_LEVEL    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        wp_n_stable,
  output logic        wp_change,
  output logic        irq,
  input  logic        irq_ack
);
  localparam int TW = $clog2(POLL_DIV);
  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
  typedef enum logic [1:0] {IDLE, READ, LAT, EVAL} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    lat_q, lat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d, sample_q, sample_d, stable_q, stable_d;
  logic          change_q, change_d, irq_q, irq_d, read_q, read_d;
  logic          expire;
  logic          unused_rd;
  assign unused_rd = ^avm_readdata[31:1];
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    stable_d = stable_q;
    change_d = 1'b0;
    timer_d  = (!enable || timer_q == '0) ? TW'(POLL_DIV - 1) : timer_q - 1'b1;
    expire   = enable && timer_q == TW'(1);
    // A new expiry wins over the IDLE consume; expiries outside IDLE coalesce.
    pend_d   = expire || (pend_q && enable && state_q != IDLE);
    case (state_q)
      IDLE: state_d = (pend_q && enable) ? READ : IDLE;
      READ: if (!avm_waitrequest) begin
        state_d = LAT;
        lat_d   = 2'(READ_LATENCY - 1);
      end
      LAT: if (lat_q == '0) begin
        state_d  = EVAL;
        sample_d = avm_readdata[0];
      end else begin
        lat_d = lat_q - 1'b1;
      end
      EVAL: begin
        state_d = IDLE;
        if (sample_q == stable_q) begin
          cnt_d = '0;
        end else if (int'(cnt_q) + 1 == DEBOUNCE_COUNT) begin
          cnt_d    = '0;
          stable_d = sample_q;
          change_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    irq_d  = change_d || (irq_q && !irq_ack);
    read_d = state_d == READ;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= TW'(POLL_DIV - 1);
      pend_q   <= 1'b0;
      lat_q    <= '0;
      cnt_q    <= '0;
      sample_q <= RESET_LEVEL;
      stable_q <= RESET_LEVEL;
      change_q <= 1'b0;
      irq_q    <= 1'b0;
      read_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      lat_q    <= lat_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      stable_q <= stable_d;
      change_q <= change_d;
      irq_q    <= irq_d;
      read_q   <= read_d;
    end
  end
  assign avm_address = 2'b00;
  assign avm_read    = read_q;
  assign wp_n_stable = stable_q;
  assign wp_change   = change_q;
  assign irq         = irq_q;
endmodule

// File: tb/tb_system_0_sd_wp_poller.sv
// tb_system_0_sd_wp_poller: directed checks of polling, debounce, stall, latency and irq.
module tb_system_0_sd_wp_poller;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, waitreq = 1'b0, irq_ack = 1'b0;
  logic [31:0] rdata = 32'h1;
  logic [1:0] addr, addr1;
  logic rd, rd1, stable, stable1, chg, chg1, irq, irq1;
  int compared = 0, mismatched = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  system_0_sd_wp_poller #(.POLL_DIV(8), .DEBOUNCE_COUNT(3), .READ_LATENCY(3), .RESET_LEVEL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .avm_address(addr), .avm_read(rd),
    .avm_waitrequest(waitreq), .avm_readdata(rdata), .wp_n_stable(stable),
    .wp_change(chg), .irq(irq), .irq_ack(irq_ack));
  system_0_sd_wp_poller #(.POLL_DIV(8), .DEBOUNCE_COUNT(3), .READ_LATENCY(1), .RESET_LEVEL(1'b1)) u_rl1 (
    .clk(clk), .reset(reset), .enable(enable), .avm_address(addr1), .avm_read(rd1),
    .avm_waitrequest(1'b0), .avm_readdata(32'h1), .wp_n_stable(stable1),
    .wp_change(chg1), .irq(irq1), .irq_ack(1'b0));

  // Random upper bits; bit 0 is the level the slave presents this cycle.
  function automatic logic [31:0] word(input logic b);
    logic [31:0] r;
    r = $urandom();
    return {r[31:1], b};
  endfunction

  // Serves one u_dut poll: valid data only in the 3rd cycle after accept, inverted level otherwise.
  task automatic poll(input logic v, input bit ack, input int stall, output int changes, output int hi, output int rise);
    int n = 0;
    while (rd !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    compared++;
    if (rd !== 1'b1) begin mismatched++; $display("FAIL poll_start: avm_read=%b after %0d cycles, want 1", rd, n); end
    rise = cyc; hi = 1; changes = 0;
    rdata = word(~v);
    forever begin
      if (hi == stall + 1) waitreq = 1'b0;
      @(negedge clk);
      if (rd !== 1'b1 || hi >= 100) break;
      hi++;
    end
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) @(negedge clk);
      rdata = word(i == 3 ? v : ~v);
      irq_ack = ack && i == 4;
      changes += int'(chg);
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (stable !== 1'b1) begin mismatched++; $display("FAIL reset_stable: got %b want 1", stable); end
    compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL reset_irq: got %b want 0", irq); end
    compared++; if (rd !== 1'b0 || rd1 !== 1'b0) begin mismatched++; $display("FAIL reset_read: got %b/%b want 0/0", rd, rd1); end
    compared++; if (chg !== 1'b0) begin mismatched++; $display("FAIL reset_change: got %b want 0", chg); end
    reset = 1'b0;
    n = 0;
    while (rd1 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    compared++; if (n != 8) begin mismatched++; $display("FAIL first_read_delay: got %0d want 8", n); end
    compared++; if (addr1 !== 2'b00) begin mismatched++; $display("FAIL address: got %0d want 0", addr1); end
    @(negedge clk);
    compared++; if (rd1 !== 1'b0) begin mismatched++; $display("FAIL read_one_cycle: got %b want 0", rd1); end
    n = 1;
    while (rd1 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    compared++; if (n != 8) begin mismatched++; $display("FAIL poll_period_rl1: got %0d want 8", n); end
    compared++; if (stable1 !== 1'b1) begin mismatched++; $display("FAIL rl1_stable: got %b want 1", stable1); end
  endtask

  task automatic test_debounce;
    logic pat [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
    logic exp [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    int ch, hi, r;
    for (int i = 0; i < 9; i++) begin
      poll(pat[i], 1'b0, 0, ch, hi, r);
      compared++; if (stable !== exp[i]) begin mismatched++; $display("FAIL debounce_stable[%0d]: got %b want %b", i, stable, exp[i]); end
      compared++; if (ch != int'(i == 8)) begin mismatched++; $display("FAIL debounce_change[%0d]: got %0d want %0d", i, ch, int'(i == 8)); end
    end
    compared++; if (irq !== 1'b1) begin mismatched++; $display("FAIL debounce_irq: got %b want 1", irq); end
  endtask

  task automatic test_irq;
    int ch, hi, r;
    irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
    compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL irq_ack_clear: got %b want 0", irq); end
    poll(1'b1, 1'b0, 0, ch, hi, r);
    poll(1'b1, 1'b0, 0, ch, hi, r);
    poll(1'b1, 1'b1, 0, ch, hi, r);
    compared++; if (stable !== 1'b1 || ch != 1) begin mismatched++; $display("FAIL irq_change: stable=%b changes=%0d want 1/1", stable, ch); end
    compared++; if (irq !== 1'b1) begin mismatched++; $display("FAIL irq_set_wins: got %b want 1", irq); end
    irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
    compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL irq_ack_later: got %b want 0", irq); end
  endtask

  task automatic test_stall;
    int ch, hi, r0, r1, r2, r3;
    waitreq = 1'b1;
    poll(1'b1, 1'b0, 20, ch, hi, r0);
    compared++; if (hi != 21) begin mismatched++; $display("FAIL stall_read_cycles: got %0d want 21", hi); end
    compared++; if (ch != 0) begin mismatched++; $display("FAIL stall_change: got %0d want 0", ch); end
    poll(1'b1, 1'b0, 0, ch, hi, r1);
    poll(1'b1, 1'b0, 0, ch, hi, r2);
    poll(1'b1, 1'b0, 0, ch, hi, r3);
    compared++; if (r1 - r0 != 26) begin mismatched++; $display("FAIL pending_after_stall: gap %0d want 26", r1 - r0); end
    compared++; if (r2 - r1 != 6) begin mismatched++; $display("FAIL next_timer_poll: gap %0d want 6", r2 - r1); end
    compared++; if (r3 - r2 != 8) begin mismatched++; $display("FAIL no_extra_read: gap %0d want 8", r3 - r2); end
  endtask

  task automatic test_enable;
    int n, seen;
    enable = 1'b0; seen = 0;
    repeat (20) begin @(negedge clk); seen += int'(rd); end
    compared++; if (seen != 0) begin mismatched++; $display("FAIL enable_off_reads: got %0d want 0", seen); end
    enable = 1'b1; n = 0;
    while (rd !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    compared++; if (n != 8) begin mismatched++; $display("FAIL enable_first_read: got %0d want 8", n); end
  endtask

  task automatic test_reset_mid_read;
    logic pat [5] = '{0, 0, 0, 1, 1};
    int ch, hi, r, n;
    for (int i = 0; i < 5; i++) poll(pat[i], 1'b0, 0, ch, hi, r);
    compared++; if (stable !== 1'b0) begin mismatched++; $display("FAIL pre_reset_stable: got %b want 0", stable); end
    waitreq = 1'b1; n = 0;
    while (rd !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    compared++; if (rd !== 1'b0) begin mismatched++; $display("FAIL mid_reset_read: got %b want 0", rd); end
    compared++; if (stable !== 1'b1 || irq !== 1'b0) begin mismatched++; $display("FAIL mid_reset_state: stable=%b irq=%b want 1/0", stable, irq); end
    reset = 1'b0; waitreq = 1'b0; n = 0;
    while (rd !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    compared++; if (n != 8) begin mismatched++; $display("FAIL restart_delay: got %0d want 8", n); end
    for (int i = 0; i < 3; i++) begin
      poll(1'b0, 1'b0, 0, ch, hi, r);
      compared++; if (stable !== logic'(i != 2) || ch != int'(i == 2)) begin
        mismatched++; $display("FAIL count_cleared[%0d]: stable=%b changes=%0d want %b/%0d", i, stable, ch, i != 2, int'(i == 2));
      end
    end
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_irq;
    test_stall;
    test_enable;
    test_reset_mid_read;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
